// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit adder with carry-in/carry-out.
// The operands are split into STAGES carry-ripple chunks of W = N/STAGES bits.
// Each chunk adds in its own pipeline stage and is separated from the next by
// a registered carry.
// Operand chunks for later stages are skewed forward in time to meet their
// incoming carry. Partial sums from earlier stages are deskewed so that every
// chunk of one operation reaches Sum in the same cycle.
// The design sustains one addition per clock with a latency of STAGES edges,
// counting the sampling edge.

module pipelined_adder #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    localparam int W = (STAGES >= 1 && STAGES <= N) ? (N / STAGES) : 1;

    // Refuse to build a pipeline whose chunks would not tile the operand width.
    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_badParams
        $error("pipelined_adder: STAGES must lie in 1..N and divide N evenly");
    end

    // Time-aligned full-width sum, assembled slice by slice from every stage.
    wire [N-1:0] w_sumAligned;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        logic [W-1:0] w_a;
        logic [W-1:0] w_b;
        logic         w_cin;
        logic [W:0]   w_add;
        logic [W-1:0] r_psum;
        logic         r_carry;

        if (k == 0) begin : g_noSkew
            // The first chunk meets Cin in the same cycle it arrives.
            assign w_a   = A[W-1:0];
            assign w_b   = B[W-1:0];
            assign w_cin = Cin;
        end else begin : g_skew
            logic [W-1:0] r_aSkew [k];
            logic [W-1:0] r_bSkew [k];

            // Delay chunk k of the operands by k cycles.
            // This lets them meet the carry rippling out of stage k-1.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < k; i++) begin
                        r_aSkew[i] <= '0;
                        r_bSkew[i] <= '0;
                    end
                end else begin
                    r_aSkew[0] <= A[k*W +: W];
                    r_bSkew[0] <= B[k*W +: W];
                    for (int i = 1; i < k; i++) begin
                        r_aSkew[i] <= r_aSkew[i-1];
                        r_bSkew[i] <= r_bSkew[i-1];
                    end
                end
            end

            assign w_a   = r_aSkew[k-1];
            assign w_b   = r_bSkew[k-1];
            assign w_cin = g_stage[k-1].r_carry;
        end

        // One extra bit on each operand captures the chunk's carry out.
        assign w_add = {1'b0, w_a} + {1'b0, w_b} + {{W{1'b0}}, w_cin};

        // Register this chunk's partial sum and the carry handed to the next chunk.
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_psum  <= '0;
                r_carry <= 1'b0;
            end else begin
                r_psum  <= w_add[W-1:0];
                r_carry <= w_add[W];
            end
        end

        if (k == STAGES - 1) begin : g_noDeskew
            // The last chunk finishes exactly when the operation leaves the pipe.
            assign w_sumAligned[k*W +: W] = r_psum;
        end else begin : g_deskew
            localparam int D = STAGES - 1 - k;
            logic [W-1:0] r_deskew [D];

            // Hold an early chunk's result until the upper chunks of the same
            // operation catch up.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int i = 0; i < D; i++) begin
                        r_deskew[i] <= '0;
                    end
                end else begin
                    r_deskew[0] <= r_psum;
                    for (int i = 1; i < D; i++) begin
                        r_deskew[i] <= r_deskew[i-1];
                    end
                end
            end

            assign w_sumAligned[k*W +: W] = r_deskew[D-1];
        end
    end

    // Outputs come straight from registers, so they change only on clock edges.
    assign Sum  = w_sumAligned;
    assign Cout = g_stage[STAGES-1].r_carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// Testbench for pipelined_adder.
// Directed vectors run against an N=8, STAGES=2 instance. A random stream is
// shared by instances with STAGES = 1, 2, 4 and 8, and each instance is
// compared every cycle with a delayed golden A+B+Cin.

module tb_pipelined_adder;

   logic       clock;
   logic       resetN;
   logic [7:0] opA;
   logic [7:0] opB;
   logic       carryIn;

   logic [7:0] sum1, sum2, sum4, sum8;
   logic       cout1, cout2, cout4, cout8;

   int testsRun;
   int testsFailed;
   int cyc;

   logic [8:0] histVal [0:2047];
   bit         histRst [0:2047];

   pipelined_adder #(.N(8), .STAGES(1)) u_dut1 (
      .clk(clock), .reset(resetN), .A(opA), .B(opB), .Cin(carryIn),
      .Sum(sum1), .Cout(cout1));
   pipelined_adder #(.N(8), .STAGES(2)) u_dut2 (
      .clk(clock), .reset(resetN), .A(opA), .B(opB), .Cin(carryIn),
      .Sum(sum2), .Cout(cout2));
   pipelined_adder #(.N(8), .STAGES(4)) u_dut4 (
      .clk(clock), .reset(resetN), .A(opA), .B(opB), .Cin(carryIn),
      .Sum(sum4), .Cout(cout4));
   pipelined_adder #(.N(8), .STAGES(8)) u_dut8 (
      .clk(clock), .reset(resetN), .A(opA), .B(opB), .Cin(carryIn),
      .Sum(sum8), .Cout(cout8));

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Golden result after the current edge for a pipeline of depth s.
   // A reset edge anywhere in the operation's flight window forces 0.
   function automatic logic [8:0] goldenOut(int s);
      if (cyc - (s - 1) < 1) return 9'd0;
      for (int d = 0; d < s; d++) begin
         if (histRst[cyc - d]) return 9'd0;
      end
      return histVal[cyc - (s - 1)];
   endfunction

   task automatic compare(string tag, logic [8:0] observed, logic [8:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed {Cout,Sum}=%0d expected %0d (cycle %0d)",
                tag, observed, expected, cyc);
      end
   endtask

   // Drive one operand set away from the active edge.
   // Record it, let the edge pass, then check every depth against the model.
   task automatic applyStimulus(logic [7:0] a, logic [7:0] b, logic c, logic rN);
      @(negedge clock);
      opA     = a;
      opB     = b;
      carryIn = c;
      resetN  = rN;
      @(posedge clock);
      cyc++;
      histVal[cyc] = {1'b0, a} + {1'b0, b} + {8'd0, c};
      histRst[cyc] = !rN;
      #1;
      compare("model_s1", {cout1, sum1}, goldenOut(1));
      compare("model_s2", {cout2, sum2}, goldenOut(2));
      compare("model_s4", {cout4, sum4}, goldenOut(4));
      compare("model_s8", {cout8, sum8}, goldenOut(8));
   endtask

   // Hand-computed check on the STAGES=2 instance.
   task automatic checkOutput(string tag, logic [7:0] expSum, logic expCout);
      compare(tag, {cout2, sum2}, {expCout, expSum});
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      cyc         = 0;
      opA         = 8'd0;
      opB         = 8'd0;
      carryIn     = 1'b0;
      resetN      = 1'b1;

      // Reset with arbitrary operands present.
      applyStimulus(8'hAA, 8'h55, 1'b1, 1'b0);
      checkOutput("reset", 8'd0, 1'b0);

      // Back-to-back directed stream.
      applyStimulus(8'd10, 8'd20, 1'b0, 1'b1);
      checkOutput("fill_after_release", 8'd0, 1'b0);
      applyStimulus(8'd255, 8'd1, 1'b1, 1'b1);
      checkOutput("basic_10_20", 8'd30, 1'b0);
      applyStimulus(8'd128, 8'd128, 1'b0, 1'b1);
      checkOutput("ripple_255_1_1", 8'd1, 1'b1);
      applyStimulus(8'd128, 8'd128, 1'b0, 1'b1);
      checkOutput("top_carry_128_128", 8'd0, 1'b1);
      applyStimulus(8'd128, 8'd128, 1'b0, 1'b1);
      checkOutput("hold_1", 8'd0, 1'b1);
      applyStimulus(8'd128, 8'd128, 1'b0, 1'b1);
      checkOutput("hold_2", 8'd0, 1'b1);

      // Reset mid-stream: the in-flight 3+4+1 and 5+5 are discarded.
      applyStimulus(8'd1, 8'd2, 1'b0, 1'b1);
      checkOutput("hold_3", 8'd0, 1'b1);
      applyStimulus(8'd3, 8'd4, 1'b1, 1'b1);
      checkOutput("pre_reset_1_2", 8'd3, 1'b0);
      applyStimulus(8'd5, 8'd5, 1'b0, 1'b0);
      checkOutput("mid_reset", 8'd0, 1'b0);
      applyStimulus(8'd6, 8'd7, 1'b0, 1'b1);
      checkOutput("post_reset_fill", 8'd0, 1'b0);
      applyStimulus(8'd9, 8'd9, 1'b1, 1'b1);
      checkOutput("post_reset_6_7", 8'd13, 1'b0);
      applyStimulus(8'd0, 8'd0, 1'b0, 1'b1);
      checkOutput("post_reset_9_9_1", 8'd19, 1'b0);

      // Random stream with one mid-stream reset to flush deeper pipelines.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(8'($urandom_range(255)), 8'($urandom_range(255)),
                       1'($urandom_range(1)), (i == 500) ? 1'b0 : 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
